out_wrapper_fifo_cu: RTL and testbench
======================================

# out_wrapper_fifo_cu

Parametrised output wrapper for the floating-point multiplier datapath. Buffers up to DEPTH results produced on `doneFP`, presents them one at a time on `resultOut`, and hands each off to the downstream consumer with a `resultReady`/`resultAccept` handshake. The handshake is either four-phase (level, accept must drop before the next word) or two-phase (single-cycle ready/accept). Sits between the FP multiplier core and the external result port, and replaces the single-entry output controller.

## Interface
- `WIDTH`, 32, result word width in bits.
- `DEPTH`, 4, buffer entries; power of two, ≥ 2.
- `FOUR_PHASE`, 1, 1 = four-phase level handshake; 0 = two-phase ready/accept.

- `clk`  in  1  clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `doneFP`  in  1  one-cycle strobe: `resultFP` is valid this cycle.
- `resultFP`  in  WIDTH  result from the FP core.
- `full`  out  1  buffer holds DEPTH entries; the core must not strobe `doneFP`.
- `overflow`  out  1  sticky; a `doneFP` arrived while `full`.
- `count`  out  $clog2(DEPTH+1)  current number of buffered entries.
- `resultOut`  out  WIDTH  word being offered downstream.
- `resultReady`  out  1  `resultOut` is valid and offered.
- `resultAccept`  in  1  consumer acknowledge.

## Operation
- **Push:** `doneFP && !full` writes `resultFP` at the write pointer, increments the write pointer (wraps modulo DEPTH) and increments `count`.
- **Push while full:** `doneFP && full` drops the word, leaves `count` and pointers unchanged, and sets `overflow`. Only `rst` clears `overflow`.
- `full` depends only on the registered `count`. A push in the same cycle as a pop with `count==DEPTH` is still dropped.
- **Simultaneous push and pop:** `count` is unchanged; both pointers advance.
- **Output FSM states:** EMPTY, LOAD, WAIT_ACCEPT, SURE_ACCEPT.
  - EMPTY: go to LOAD if `count!=0`, else stay. `resultReady=0`.
  - LOAD: `resultOut <= mem[rptr]`, go to WAIT_ACCEPT. `resultReady=0`.
  - WAIT_ACCEPT: `resultReady=1`. On `resultAccept`, pop (rptr++, count−−) at that edge.
    - FOUR_PHASE=1: go to SURE_ACCEPT.
    - FOUR_PHASE=0: go to LOAD if the post-pop count is nonzero, else EMPTY.
  - SURE_ACCEPT (FOUR_PHASE=1 only): `resultReady=0`. Stay while `resultAccept` is high. When it is low, go to LOAD if `count!=0`, else EMPTY.
- `resultOut` holds its value from LOAD until the next LOAD. It is stable throughout WAIT_ACCEPT and SURE_ACCEPT.
- `resultAccept` is ignored outside WAIT_ACCEPT.
- **Reset (any time, including mid-handshake):** state=EMPTY, pointers=0, `count`=0, `full`=0, `overflow`=0, `resultReady`=0, `resultOut`=0. Buffered data is discarded. Memory contents are not reset.

## Timing
- **Latency:** `doneFP` sampled at edge k into an empty buffer gives `count=1` after k, LOAD after k+1, WAIT_ACCEPT after k+2. `resultReady` is high in the cycle following edge k+2, i.e. 3 cycles after the strobe.
- **Two-phase throughput:** one word per 2 cycles (WAIT_ACCEPT/LOAD alternation) when `resultAccept` is held high.
- **Four-phase throughput:** a minimum of 3 cycles per word (WAIT_ACCEPT, SURE_ACCEPT with accept low, LOAD).
- `full` and `count` update on the edge after the push or pop that changes them.
- `resultReady` is a registered-state decode. It must not depend combinationally on `resultAccept`.

## Structure
- **Shared package `fp_wrap_pkg`:**
  - the output state enum (EMPTY, LOAD, WAIT_ACCEPT, SURE_ACCEPT);
  - a `handshake_mode_t` constant pair (TWO_PHASE=0, FOUR_PHASE=1).
- **Sub-module `out_result_fifo`:** parametrised storage with write/read pointers, `count`, `full`/`empty` and `overflow`.
- The top level holds the output FSM and the `resultOut` register.

## Test plan
- **Latency/reset values:** Reset, then one `doneFP` with `resultFP=32'h3F800000`. Required: `resultReady` rises exactly 3 cycles later with `resultOut=32'h3F800000`. All outputs are 0 during reset.
- **Four-phase ordering:** DEPTH=4, FOUR_PHASE=1. Push 32'h1, 32'h2, 32'h3 back-to-back; accept each by raising `resultAccept` for 2 cycles, then dropping it. Required: words emerge in order 1, 2, 3. `resultReady` stays low while accept is high in SURE_ACCEPT. `count` steps 3→2→1→0.
- **Two-phase throughput:** FOUR_PHASE=0, `resultAccept` tied high, push 4 words. Required: a pop every 2 cycles; `full` is high only for the cycle(s) with `count=4`.
- **Overflow:** fill 4 entries with no accept, then strobe `doneFP` with 32'hDEAD. Required: `overflow=1`, `count` stays 4, 32'hDEAD never appears on `resultOut`. After draining, `overflow` is still 1.
- **Wrap-around / simultaneous push-pop:** 10 pushes interleaved with accepts, including a push in the same cycle as a pop. Required: in-order data, `count` unchanged on the simultaneous cycle, pointer wrap transparent.
- **Reset mid-handshake:** assert `rst` low in WAIT_ACCEPT with `count=2`. Required: immediate `resultReady=0` and `count=0`; after release, no stale word is offered.

Source files
------------

// File: rtl/fp_wrap_pkg.sv
// Shared types for the FP multiplier output wrapper: output FSM states and handshake modes.
package fp_wrap_pkg;

  typedef enum logic [1:0] {
    StEmpty,
    StLoad,
    StWaitAccept,
    StSureAccept
  } out_state_e;

  typedef enum logic {
    TwoPhase  = 1'b0,
    FourPhase = 1'b1
  } handshake_mode_t;

endpackage

// File: rtl/out_result_fifo.sv
// Result buffer: DEPTH-entry circular store with occupancy count and sticky overflow flag.
module out_result_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic             overflow_q;
  logic             push_ok, pop_ok;

  // full is decoded from the registered count only, so a push alongside a pop at DEPTH is dropped
  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    count_d = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + PtrW'(1);
      if (pop_ok)  rptr_q <= rptr_q + PtrW'(1);
      if (push && full) overflow_q <= 1'b1;
      count_q <= count_d;
    end
  end

  // Storage is intentionally left out of reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr_q] <= wdata;
  end

  assign rdata    = mem[rptr_q];
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: rtl/out_wrapper_fifo_cu.sv
// Output wrapper: buffers FP results and offers them downstream over a two- or four-phase handshake.
module out_wrapper_fifo_cu
  import fp_wrap_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH      = 4,
  parameter bit          FOUR_PHASE = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       doneFP,
  input  logic [WIDTH-1:0]           resultFP,
  output logic                       full,
  output logic                       overflow,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [WIDTH-1:0]           resultOut,
  output logic                       resultReady,
  input  logic                       resultAccept
);

  localparam int unsigned     CntW = $clog2(DEPTH+1);
  localparam handshake_mode_t Mode = handshake_mode_t'(FOUR_PHASE);

  out_state_e       state_q, state_d;
  logic [WIDTH-1:0] result_out_q, result_out_d;
  logic [WIDTH-1:0] fifo_rdata;
  logic             fifo_empty;
  logic             pop;

  out_result_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (doneFP),
    .wdata    (resultFP),
    .pop      (pop),
    .rdata    (fifo_rdata),
    .count    (count),
    .full     (full),
    .empty    (fifo_empty),
    .overflow (overflow)
  );

  always_comb begin
    state_d      = state_q;
    result_out_d = result_out_q;
    pop          = 1'b0;
    unique case (state_q)
      StEmpty: begin
        if (!fifo_empty) state_d = StLoad;
      end
      StLoad: begin
        result_out_d = fifo_rdata;
        state_d      = StWaitAccept;
      end
      StWaitAccept: begin
        if (resultAccept) begin
          pop = 1'b1;
          if (Mode == FourPhase) begin
            state_d = StSureAccept;
          // Post-pop occupancy counts a push landing on the same edge.
          end else if ((count > CntW'(1)) || (doneFP && !full)) begin
            state_d = StLoad;
          end else begin
            state_d = StEmpty;
          end
        end
      end
      StSureAccept: begin
        if (!resultAccept) state_d = fifo_empty ? StEmpty : StLoad;
      end
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StEmpty;
      result_out_q <= '0;
    end else begin
      state_q      <= state_d;
      result_out_q <= result_out_d;
    end
  end

  assign resultReady = (state_q == StWaitAccept);
  assign resultOut   = result_out_q;

endmodule

// File: tb/tb_out_wrapper_fifo_cu.sv
// Self-checking bench: four-phase and two-phase instances against a queue-level protocol model.
module tb_out_wrapper_fifo_cu;

  localparam int unsigned W  = 32;
  localparam int unsigned D  = 4;
  localparam int unsigned CW = $clog2(D+1);
  localparam int          MB = 16;

  logic          clk  = 1'b0;
  logic          rst  = 1'b1;
  logic          done = 1'b0;
  logic [W-1:0]  data = '0;
  logic          acc4 = 1'b0;
  logic          acc2 = 1'b0;

  logic          full4, ovf4, rdy4, full2, ovf2, rdy2;
  logic [CW-1:0] cnt4, cnt2;
  logic [W-1:0]  out4, out2;

  int checks = 0;
  int passes = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  out_wrapper_fifo_cu #(.WIDTH(W), .DEPTH(D), .FOUR_PHASE(1'b1)) u_dut4 (
    .clk          (clk),
    .rst          (rst),
    .doneFP       (done),
    .resultFP     (data),
    .full         (full4),
    .overflow     (ovf4),
    .count        (cnt4),
    .resultOut    (out4),
    .resultReady  (rdy4),
    .resultAccept (acc4)
  );

  out_wrapper_fifo_cu #(.WIDTH(W), .DEPTH(D), .FOUR_PHASE(1'b0)) u_dut2 (
    .clk          (clk),
    .rst          (rst),
    .doneFP       (done),
    .resultFP     (data),
    .full         (full2),
    .overflow     (ovf2),
    .count        (cnt2),
    .resultOut    (out2),
    .resultReady  (rdy2),
    .resultAccept (acc2)
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: actual=%h required=%h t=%0t", name, act, exp, $time);
  endtask

  // Model: index 0 = four-phase, 1 = two-phase. Queue as head/size over a wide ring.
  // ph: 0 idle, 1 fetching, 2 offering, 3 waiting for accept release.
  int           sz   [2];
  int           hd   [2];
  int           ph   [2];
  logic [W-1:0] mbuf [2][MB];
  bit           movf [2];
  logic [W-1:0] mout [2];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int m = 0; m < 2; m++) begin
        sz[m] <= 0; hd[m] <= 0; ph[m] <= 0; movf[m] <= 1'b0; mout[m] <= '0;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        automatic bit four   = (m == 0);
        automatic bit acc    = (m == 0) ? acc4 : acc2;
        automatic bit pushok = done && (sz[m] != D);
        automatic bit pop    = (ph[m] == 2) && acc;
        case (ph[m])
          0: if (sz[m] != 0) ph[m] <= 1;
          1: begin mout[m] <= mbuf[m][hd[m]]; ph[m] <= 2; end
          2: if (acc) begin
               if (four) ph[m] <= 3;
               else ph[m] <= ((sz[m] - 1 + int'(pushok)) != 0) ? 1 : 0;
             end
          3: if (!acc) ph[m] <= (sz[m] != 0) ? 1 : 0;
          default: ;
        endcase
        if (pushok) mbuf[m][(hd[m] + sz[m]) % MB] <= data;
        else if (done) movf[m] <= 1'b1;
        hd[m] <= pop ? (hd[m] + 1) % MB : hd[m];
        sz[m] <= sz[m] - int'(pop) + int'(pushok);
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("ready4", 32'(rdy4),  32'(ph[0] == 2));
      chk("out4",   out4,       mout[0]);
      chk("count4", 32'(cnt4),  sz[0]);
      chk("full4",  32'(full4), 32'(sz[0] == D));
      chk("ovf4",   32'(ovf4),  32'(movf[0]));
      chk("ready2", 32'(rdy2),  32'(ph[1] == 2));
      chk("out2",   out2,       mout[1]);
      chk("count2", 32'(cnt2),  sz[1]);
      chk("full2",  32'(full2), 32'(sz[1] == D));
      chk("ovf2",   32'(ovf2),  32'(movf[1]));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_rdy4();
    int i = 0;
    while (!rdy4 && i < 30) begin tick(); i++; end
    if (!rdy4) chk("wait_rdy4", 32'(rdy4), 32'd1);
  endtask

  task automatic drain();
    done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      acc4 = 1'((i % 2) == 0);
      acc2 = acc4;
      tick();
    end
    acc4 = 1'b0; acc2 = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int          exp_cnt [10];
    bit          exp_rdy [10];
    logic [31:0] wv;
    exp_cnt = '{1, 2, 3, 3, 3, 2, 2, 1, 1, 0};
    exp_rdy = '{0, 0, 1, 0, 1, 0, 1, 0, 1, 0};

    // Reset values
    #2 rst = 1'b0;
    #1 cmp_en = 1'b1;
    chk("rst_ready4", 32'(rdy4), 32'd0);
    chk("rst_out4",   out4,      32'd0);
    chk("rst_count4", 32'(cnt4), 32'd0);
    chk("rst_full4",  32'(full4), 32'd0);
    chk("rst_ovf2",   32'(ovf2), 32'd0);
    repeat (2) tick();
    rst = 1'b1;

    // Latency: ready exactly three cycles after the strobe
    done = 1'b1; data = 32'h3F80_0000;
    tick();
    done = 1'b0;
    chk("lat_k_ready4", 32'(rdy4), 32'd0);
    chk("lat_k_count4", 32'(cnt4), 32'd1);
    tick();
    chk("lat_k1_ready4", 32'(rdy4), 32'd0);
    tick();
    chk("lat_k2_ready4", 32'(rdy4), 32'd1);
    chk("lat_k2_out4",   out4,      32'h3F80_0000);
    chk("lat_k2_ready2", 32'(rdy2), 32'd1);
    chk("lat_k2_out2",   out2,      32'h3F80_0000);
    acc4 = 1'b1; acc2 = 1'b1;
    tick();
    acc4 = 1'b0; acc2 = 1'b0;
    repeat (4) tick();

    // Four-phase ordering
    for (int w = 1; w <= 3; w++) begin
      done = 1'b1; data = 32'(w);
      tick();
    end
    done = 1'b0;
    for (int w = 1; w <= 3; w++) begin
      wait_rdy4();
      chk("fp_order_out4",   out4,      32'(w));
      chk("fp_order_count4", 32'(cnt4), 32'(4 - w));
      acc4 = 1'b1; acc2 = 1'b1;
      tick();
      chk("fp_sure_ready4_a", 32'(rdy4), 32'd0);
      tick();
      chk("fp_sure_ready4_b", 32'(rdy4), 32'd0);
      acc4 = 1'b0; acc2 = 1'b0;
      tick();
    end
    repeat (3) tick();
    chk("fp_final_count4", 32'(cnt4), 32'd0);
    drain();

    // Two-phase throughput with accept held high; four-phase instance fills up
    acc2 = 1'b1; acc4 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      done = (i < 4);
      data = 32'hA0 + 32'(i);
      tick();
      chk("tp_ready2", 32'(rdy2), 32'(exp_rdy[i]));
      chk("tp_count2", 32'(cnt2), 32'(exp_cnt[i]));
    end
    done = 1'b0; acc2 = 1'b0;
    chk("fill_full4",  32'(full4), 32'd1);
    chk("fill_count4", 32'(cnt4),  32'd4);

    // Overflow on the full four-phase instance
    done = 1'b1; data = 32'hDEAD;
    tick();
    done = 1'b0;
    tick();
    chk("ovf_flag4",  32'(ovf4), 32'd1);
    chk("ovf_count4", 32'(cnt4), 32'd4);
    for (int i = 0; i < 40; i++) begin
      acc4 = 1'((i % 2) == 0);
      acc2 = acc4;
      tick();
      chk("ovf_no_dead4", 32'(out4 == 32'hDEAD), 32'd0);
    end
    acc4 = 1'b0; acc2 = 1'b0;
    repeat (3) tick();
    chk("ovf_sticky4",  32'(ovf4), 32'd1);
    chk("ovf_drained4", 32'(cnt4), 32'd0);
    drain();

    // Random traffic: wrap-around, simultaneous push/pop, occasional overflow
    for (int i = 0; i < 400; i++) begin
      done = 1'($urandom_range(0, 1));
      wv   = $urandom;
      data = wv;
      acc4 = 1'($urandom_range(0, 3) != 0);
      acc2 = 1'($urandom_range(0, 1));
      tick();
    end
    drain();

    // Reset mid-handshake
    done = 1'b1; data = 32'h111;
    tick();
    data = 32'h222;
    tick();
    done = 1'b0;
    wait_rdy4();
    chk("mid_count4", 32'(cnt4), 32'd2);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_ready4", 32'(rdy4), 32'd0);
    chk("mid_rst_count4", 32'(cnt4), 32'd0);
    chk("mid_rst_out4",   out4,      32'd0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("mid_no_stale4", 32'(rdy4), 32'd0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
